// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared line geometry and FSM state type for the pmem responder
package pmem_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef logic [LINE_WIDTH-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_array.sv
// rtl/pmem_line_array.sv - line storage with one registered read port and one write port
module pmem_line_array
  import pmem_pkg::*;
#(
  parameter int INDEX_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] rindex,
  output line_t                 rdata,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] windex,
  input  line_t                 wdata
);

  localparam int DEPTH = 1 << INDEX_BITS;

  line_t mem [DEPTH];

  // Contents are deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[windex] <= wdata;
    end
  end

  // Output holds its value between reads so the last read line stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[rindex];
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency line memory answering the cache pmem interface
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int INDEX_BITS    = 10,
  parameter int READ_LATENCY  = 10,
  parameter int WRITE_LATENCY = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  line_t       pmem_wdata,
  output line_t       pmem_rdata,
  output logic        pmem_resp,
  output logic        proto_err
);

  localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pmem_state_t           state;
  logic [CNT_W-1:0]      count;
  logic                  op_write;
  logic [INDEX_BITS-1:0] idx_q;
  line_t                 wdata_q;

  logic [INDEX_BITS-1:0] req_idx;
  logic                  req_any;
  logic                  req_is_write;
  logic                  req_lat_one;
  logic                  req_dropped;
  logic                  arr_re;
  logic [INDEX_BITS-1:0] arr_rindex;
  logic                  arr_we;
  logic                  unused_addr_bits;

  assign req_idx      = pmem_address[OFFSET_BITS +: INDEX_BITS];
  assign req_any      = pmem_read | pmem_write;
  // A simultaneous read and write is serviced as a read.
  assign req_is_write = pmem_write & ~pmem_read;
  assign req_lat_one  = req_is_write ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);
  assign req_dropped  = op_write ? ~pmem_write : ~pmem_read;

  assign unused_addr_bits = ^{pmem_address[31:OFFSET_BITS+INDEX_BITS],
                              pmem_address[OFFSET_BITS-1:0]};

  // The array read is launched one cycle ahead so its registered output lands in RESP.
  always_comb begin
    arr_re     = 1'b0;
    arr_rindex = idx_q;
    if (state == IDLE && req_any && !req_is_write && READ_LATENCY == 1) begin
      arr_re     = 1'b1;
      arr_rindex = req_idx;
    end else if (state == BUSY && !op_write && count == CNT_ONE) begin
      arr_re = 1'b1;
    end
  end

  assign arr_we    = (state == RESP) && op_write && !rst;
  assign pmem_resp = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      proto_err <= 1'b0;
      op_write  <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            op_write <= req_is_write;
            idx_q    <= req_idx;
            wdata_q  <= pmem_wdata;
            count    <= req_is_write ? WR_LOAD : RD_LOAD;
            if (pmem_read && pmem_write) begin
              proto_err <= 1'b1;
            end
            state <= req_lat_one ? RESP : BUSY;
          end
        end
        BUSY: begin
          count <= count - CNT_ONE;
          // The latched copy completes even if the initiator lets go early.
          if (req_dropped) begin
            proto_err <= 1'b1;
          end
          if (count == CNT_ONE) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  pmem_line_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .re    (arr_re),
    .rindex(arr_rindex),
    .rdata (pmem_rdata),
    .we    (arr_we),
    .windex(idx_q),
    .wdata (wdata_q)
  );

endmodule
